// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap sequencer.
// Holds mstatus/mie/mip/mtvec/mepc/mcause/mscratch. Takes traps and mret, and
// returns the redirect target in the same cycle.
// Optional feature macro VESP_CSR_COUNTERS_EN adds the 64-bit mcycle/minstret
// counters and their read-only cycle/instret shadows.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0004,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] csrAddr,
  input  logic [31:0] csrWrData,
  input  logic        csrWr,
  output logic [31:0] csrRdData,
  input  logic        exception,
  input  logic [30:0] excCode,
  input  logic        mret,
  input  logic [31:0] pc,
  input  logic        instrValid,
  input  logic        irqExt,
  output logic        interrupt,
  output logic        trapTaken,
  output logic [31:0] trapVec,
  output logic        illegalCsr
);

  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [1:0]  mstatus_mpp_q, mstatus_mpp_d;
  logic [31:0] mie_q, mie_d;
  logic        meip_q, meip_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mscratch_q, mscratch_d;
`ifdef VESP_CSR_COUNTERS_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`endif

  logic        take_irq;
  logic        trap;
  logic        wr_en;
  logic        csr_hit;
  logic [31:0] tvec_base;

  // Interrupt is gated only by architectural state, so it is naturally 0 after reset.
  assign take_irq  = instrValid & mstatus_mie_q & mie_q[11] & meip_q;
  assign trap      = take_irq | exception;
  // A CSR write loses to any trap or mret in the same cycle.
  assign wr_en     = csrWr & ~trap & ~mret;
  assign tvec_base = {mtvec_q[31:2], 2'b00};

  assign interrupt  = take_irq;
  assign trapTaken  = ~reset & (trap | mret);
  assign illegalCsr = ~reset & csrWr & ~csr_hit;

  // Redirect target: vectored mode offsets interrupts by 4*cause (cause 11).
  always_comb begin
    if (trap) begin
      if (mtvec_q[1:0] == 2'b01 && take_irq) trapVec = tvec_base + 32'd44;
      else                                   trapVec = tvec_base;
    end else begin
      trapVec = mepc_q;
    end
  end

  // Combinational read of the pre-write value; unmapped addresses read 0.
  always_comb begin
    csr_hit   = 1'b1;
    csrRdData = '0;
    case (csrAddr)
      12'h300: csrRdData = {19'd0, mstatus_mpp_q, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      12'h301: csrRdData = MISA_VALUE;
      12'h304: csrRdData = mie_q;
      12'h305: csrRdData = mtvec_q;
      12'h340: csrRdData = mscratch_q;
      12'h341: csrRdData = mepc_q;
      12'h342: csrRdData = mcause_q;
      12'h344: csrRdData = {20'd0, meip_q, 11'd0};
      12'hF14: csrRdData = '0;
`ifdef VESP_CSR_COUNTERS_EN
      12'hB00, 12'hC00: csrRdData = mcycle_q[31:0];
      12'hB80, 12'hC80: csrRdData = mcycle_q[63:32];
      12'hB02, 12'hC02: csrRdData = minstret_q[31:0];
      12'hB82, 12'hC82: csrRdData = minstret_q[63:32];
`endif
      default: csr_hit = 1'b0;
    endcase
  end

  // Next-state: trap beats mret beats CSR write; RO and mip writes are dropped.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mstatus_mpp_d  = mstatus_mpp_q;
    mie_d          = mie_q;
    meip_d         = irqExt;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mscratch_d     = mscratch_q;
    if (trap) begin
      mepc_d         = {pc[31:2], 2'b00};
      mcause_d       = take_irq ? 32'h8000_000B : {1'b0, excCode};
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mstatus_mpp_d  = 2'b11;
    end else if (mret) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
      mstatus_mpp_d  = 2'b00;
    end
    if (wr_en) begin
      case (csrAddr)
        12'h300: begin
          mstatus_mie_d  = csrWrData[3];
          mstatus_mpie_d = csrWrData[7];
          // Only M (11) and U (00) are supported privilege levels.
          if (csrWrData[12:11] == 2'b00 || csrWrData[12:11] == 2'b11)
            mstatus_mpp_d = csrWrData[12:11];
        end
        12'h304: mie_d      = csrWrData;
        12'h305: mtvec_d    = {csrWrData[31:2], 1'b0, csrWrData[0]};
        12'h340: mscratch_d = csrWrData;
        12'h341: mepc_d     = {csrWrData[31:2], 2'b00};
        12'h342: mcause_d   = csrWrData;
        default: ;
      endcase
    end
  end

`ifdef VESP_CSR_COUNTERS_EN
  // Counters: a write to either half replaces it and skips that cycle's increment.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = (instrValid & ~take_irq & ~exception) ? minstret_q + 64'd1 : minstret_q;
    if (wr_en) begin
      case (csrAddr)
        12'hB00: mcycle_d   = {mcycle_q[63:32], csrWrData};
        12'hB80: mcycle_d   = {csrWrData, mcycle_q[31:0]};
        12'hB02: minstret_d = {minstret_q[63:32], csrWrData};
        12'hB82: minstret_d = {csrWrData, minstret_q[31:0]};
        default: ;
      endcase
    end
  end
`endif

  // State register; reset wins over any trap in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mstatus_mpp_q  <= 2'b11;
      mie_q          <= '0;
      meip_q         <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mscratch_q     <= '0;
`ifdef VESP_CSR_COUNTERS_EN
      mcycle_q       <= '0;
      minstret_q     <= '0;
`endif
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mstatus_mpp_q  <= mstatus_mpp_d;
      mie_q          <= mie_d;
      meip_q         <= meip_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mscratch_q     <= mscratch_d;
`ifdef VESP_CSR_COUNTERS_EN
      mcycle_q       <= mcycle_d;
      minstret_q     <= minstret_d;
`endif
    end
  end

endmodule
